// File: rtl/disp_src_sel_if.sv
// Bus between the mode sources and the display-source selector.
// The master side drives sources, select, override and edit mask; the slave returns the display word and status.
interface disp_src_sel_if #(
    parameter int NCH  = 4,
    parameter int NDIG = 4,
    parameter int DW   = 4
);
    logic [NCH-1:0]          sel_onehot;
    logic [NCH*NDIG*DW-1:0]  src_data;
    logic                    ovr_en;
    logic [NDIG*DW-1:0]      ovr_data;
    logic [NDIG-1:0]         edit_mask;
    logic [NDIG*DW-1:0]      disp_out;
    logic [$clog2(NCH)-1:0]  cur_ch;
    logic                    blank_active;
    logic                    sel_err;

    modport master (
        output sel_onehot, src_data, ovr_en, ovr_data, edit_mask,
        input  disp_out, cur_ch, blank_active, sel_err
    );

    modport slave (
        input  sel_onehot, src_data, ovr_en, ovr_data, edit_mask,
        output disp_out, cur_ch, blank_active, sel_err
    );
endinterface

// File: rtl/disp_src_sel.sv
// Registered display-source selector: one-hot mode select with validation, blanking on channel change,
// per-digit edit blink, and a minigame override word that wins over everything else.
module disp_src_sel #(
    parameter int              NCH        = 4,
    parameter int              NDIG       = 4,
    parameter int              DW         = 4,
    parameter int              BLINK_DIV  = 25_000_000,
    parameter int              BLANK_CYC  = 4,
    parameter logic [DW-1:0]   BLANK_CODE = 4'hF
) (
    input  logic           clk,
    input  logic           rst,
    disp_src_sel_if.slave  bus
);
    localparam int CW        = $clog2(NCH);
    localparam int BW        = $clog2(BLANK_CYC + 2);
    localparam int KW        = $clog2(BLINK_DIV);
    localparam int BCNT_LOAD = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam int WW        = NDIG * DW;

    typedef enum logic [0:0] {
        SHOW,
        BLANK
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cur_ch;
    logic [CW-1:0]     cur_ch_next;
    logic [BW-1:0]     bcnt;
    logic [BW-1:0]     bcnt_next;

    logic [KW-1:0]     blink_cnt;
    logic [KW-1:0]     blink_cnt_next;
    logic              blink_phase;
    logic              phase_next;
    logic [NDIG-1:0]   prev_mask;
    logic              mask_rise;

    logic              sel_valid;
    logic [CW-1:0]     cand_idx;
    logic [CW-1:0]     cand;
    logic [WW-1:0]     src_word;
    logic [WW-1:0]     disp_next;
    logic [WW-1:0]     disp_q;
    logic              sel_err_q;

    // Anything other than exactly one select bit falls back to the current-time channel.
    always_comb begin
        sel_valid = (bus.sel_onehot != '0) &&
                    ((bus.sel_onehot & (bus.sel_onehot - {{(NCH-1){1'b0}}, 1'b1})) == '0);
        cand_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.sel_onehot[i]) begin
                cand_idx = CW'(i);
            end
        end
        cand = sel_valid ? cand_idx : '0;
    end

    always_comb begin
        state_next  = state;
        cur_ch_next = cur_ch;
        bcnt_next   = bcnt;
        case (state)
            SHOW: begin
                if (cand != cur_ch) begin
                    cur_ch_next = cand;
                    if (BLANK_CYC > 0) begin
                        state_next = BLANK;
                        bcnt_next  = BW'(BCNT_LOAD);
                    end
                end
            end
            BLANK: begin
                if (cand != cur_ch) begin
                    cur_ch_next = cand;
                    bcnt_next   = BW'(BCNT_LOAD);
                end else if (bcnt == '0) begin
                    state_next = SHOW;
                end else begin
                    bcnt_next = bcnt - BW'(1);
                end
            end
            default: begin
                state_next = SHOW;
            end
        endcase
    end

    // A fresh edit session restarts the blink so the edited digits show first.
    always_comb begin
        mask_rise      = (prev_mask == '0) && (bus.edit_mask != '0);
        blink_cnt_next = blink_cnt + KW'(1);
        phase_next     = blink_phase;
        if (mask_rise) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt == KW'(BLINK_DIV - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~blink_phase;
        end
    end

    always_comb begin
        src_word  = bus.src_data[int'(cur_ch_next) * WW +: WW];
        disp_next = src_word;
        if (bus.ovr_en) begin
            disp_next = bus.ovr_data;
        end else if (state_next == BLANK) begin
            disp_next = {NDIG{BLANK_CODE}};
        end else begin
            for (int d = 0; d < NDIG; d++) begin
                if (bus.edit_mask[d] && !phase_next) begin
                    disp_next[d*DW +: DW] = BLANK_CODE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SHOW;
            cur_ch      <= '0;
            bcnt        <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            prev_mask   <= '0;
            disp_q      <= {NDIG{BLANK_CODE}};
            sel_err_q   <= 1'b0;
        end else begin
            state       <= state_next;
            cur_ch      <= cur_ch_next;
            bcnt        <= bcnt_next;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= phase_next;
            prev_mask   <= bus.edit_mask;
            disp_q      <= disp_next;
            sel_err_q   <= !sel_valid;
        end
    end

    assign bus.disp_out     = disp_q;
    assign bus.cur_ch       = cur_ch;
    assign bus.blank_active = (state == BLANK);
    assign bus.sel_err      = sel_err_q;
endmodule

// File: tb/tb_disp_src_sel.sv
// Directed bench for disp_src_sel with short blank and blink periods; expected outputs go through a
// scoreboard queue and are checked one cycle after each stimulus edge.
module tb_disp_src_sel;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct {
        string       tag;
        logic [15:0] disp;
        logic [1:0]  ch;
        logic        blank;
        logic        err;
    } exp_t;

    exp_t sb[$];

    disp_src_sel_if #(.NCH(4), .NDIG(4), .DW(4)) bus ();

    disp_src_sel #(
        .NCH(4), .NDIG(4), .DW(4),
        .BLINK_DIV(8), .BLANK_CYC(4), .BLANK_CODE(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_field(input string tag, input string field,
                               input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [15:0] disp, input logic [1:0] ch,
                                  input logic blank, input logic err);
        exp_t e;
        e.tag   = tag;
        e.disp  = disp;
        e.ch    = ch;
        e.blank = blank;
        e.err   = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            return;
        end
        e = sb.pop_front();
        check_field(e.tag, "disp_out", bus.disp_out, e.disp);
        check_field(e.tag, "cur_ch", {14'd0, bus.cur_ch}, {14'd0, e.ch});
        check_field(e.tag, "blank_active", {15'd0, bus.blank_active}, {15'd0, e.blank});
        check_field(e.tag, "sel_err", {15'd0, bus.sel_err}, {15'd0, e.err});
    endtask

    task automatic step(input string tag, input logic [15:0] disp, input logic [1:0] ch,
                        input logic blank, input logic err);
        apply_stimulus(tag, disp, ch, blank, err);
        check_output();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.sel_onehot = 4'b0001;
        bus.src_data   = {16'hABCD, 16'h0930, 16'h5678, 16'h1234};
        bus.ovr_en     = 1'b0;
        bus.ovr_data   = 16'h0000;
        bus.edit_mask  = 4'b0000;

        $display("[TB] reset and first display");
        step("rst0", 16'hFFFF, 2'd0, 1'b0, 1'b0);
        step("rst1", 16'hFFFF, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step("release", 16'h1234, 2'd0, 1'b0, 1'b0);
        step("hold_ch0", 16'h1234, 2'd0, 1'b0, 1'b0);

        $display("[TB] channel change with blanking");
        bus.sel_onehot = 4'b0100;
        for (int i = 0; i < 4; i++) step("blank_ch2", 16'hFFFF, 2'd2, 1'b1, 1'b0);
        step("show_ch2", 16'h0930, 2'd2, 1'b0, 1'b0);

        $display("[TB] invalid selects");
        bus.sel_onehot = 4'b0110;
        step("sel_multi", 16'hFFFF, 2'd0, 1'b1, 1'b1);
        bus.sel_onehot = 4'b0000;
        step("sel_zero", 16'hFFFF, 2'd0, 1'b1, 1'b1);
        bus.sel_onehot = 4'b0001;
        step("err_clear", 16'hFFFF, 2'd0, 1'b1, 1'b0);
        step("blank_ch0", 16'hFFFF, 2'd0, 1'b1, 1'b0);
        step("show_ch0", 16'h1234, 2'd0, 1'b0, 1'b0);

        $display("[TB] override during blank");
        bus.sel_onehot = 4'b0010;
        step("blank_ch1", 16'hFFFF, 2'd1, 1'b1, 1'b0);
        bus.ovr_en   = 1'b1;
        bus.ovr_data = 16'h0003;
        for (int i = 0; i < 3; i++) step("ovr_blank", 16'h0003, 2'd1, 1'b1, 1'b0);
        step("ovr_show", 16'h0003, 2'd1, 1'b0, 1'b0);
        bus.ovr_en = 1'b0;
        step("ovr_drop", 16'h5678, 2'd1, 1'b0, 1'b0);

        $display("[TB] edit blink");
        bus.sel_onehot = 4'b0001;
        for (int i = 0; i < 4; i++) step("blank_back0", 16'hFFFF, 2'd0, 1'b1, 1'b0);
        step("back0", 16'h1234, 2'd0, 1'b0, 1'b0);
        bus.edit_mask = 4'b0011;
        for (int i = 0; i < 24; i++)
            step("blink", (((i / 8) % 2) == 0) ? 16'h1234 : 16'h12FF, 2'd0, 1'b0, 1'b0);
        bus.edit_mask = 4'b0000;
        for (int i = 0; i < 3; i++) step("mask_off", 16'h1234, 2'd0, 1'b0, 1'b0);
        bus.edit_mask = 4'b0011;
        for (int i = 0; i < 9; i++)
            step("blink_restart", (i < 8) ? 16'h1234 : 16'h12FF, 2'd0, 1'b0, 1'b0);
        bus.edit_mask = 4'b0000;

        $display("[TB] reset mid-blank");
        bus.sel_onehot = 4'b1000;
        step("blank_ch3_a", 16'hFFFF, 2'd3, 1'b1, 1'b0);
        step("blank_ch3_b", 16'hFFFF, 2'd3, 1'b1, 1'b0);
        rst = 1'b1;
        step("rst_mid", 16'hFFFF, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.sel_onehot = 4'b0001;
        step("after_rst", 16'h1234, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
